// File: rtl/wb_reg_file.sv
// 32x32 register file fed by writeback, with write-through bypass
// and a per-register pending-write scoreboard for RAW stalls.
module wb_reg_file #(
  parameter int unsigned MAX_PEND  = 3,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        iss_valid,
  input  logic        iss_we,
  input  logic [4:0]  iss_dst,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        stall,
  output logic        sb_err
);

  localparam int PW = (MAX_PEND < 2) ? 1 : $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [31:0]   regs     [32];
  logic [PW-1:0] pend     [32];
  logic [PW-1:0] pend_nxt [32];
  logic [31:0]   inc_v;
  logic [31:0]   dec_v;
  logic          err_set;
  logic          rs_hit;
  logic          rt_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wb_we && wb_dst != 5'd0) begin
      regs[wb_dst] <= wb_data;
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < 32; r++) begin
      inc_v[r] = iss_valid && iss_we && iss_dst == 5'(r);
      dec_v[r] = wb_we && wb_dst == 5'(r);
    end
  end

  // Simultaneous issue and retire on one register cancel out.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < 32; r++) begin
      pend_nxt[r] = pend[r];
      unique case (1'b1)
        inc_v[r] && !dec_v[r]: begin
          if (pend[r] == PMAX) err_set = 1'b1;
          else pend_nxt[r] = pend[r] + PONE;
        end
        dec_v[r] && !inc_v[r]: begin
          if (pend[r] == '0) err_set = 1'b1;
          else pend_nxt[r] = pend[r] - PONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        pend[i] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        pend[i] <= pend_nxt[i];
      end
      if (err_set) sb_err <= 1'b1;
    end
  end

  // Bypass is suppressed while in reset so reads show reset contents.
  assign rs_hit = rst_n && wb_we
               && wb_dst == rs_addr && rs_addr != 5'd0;
  assign rt_hit = rst_n && wb_we
               && wb_dst == rt_addr && rt_addr != 5'd0;

  assign rs_data = (rs_addr == 5'd0) ? 32'd0
                 : rs_hit ? wb_data : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0
                 : rt_hit ? wb_data : regs[rt_addr];

  assign rs_busy = rs_addr != 5'd0
                && pend[rs_addr] != '0
                && !(pend[rs_addr] == PONE && rs_hit);
  assign rt_busy = rt_addr != 5'd0
                && pend[rt_addr] != '0
                && !(pend[rt_addr] == PONE && rt_hit);

  assign stall = rs_busy | rt_busy;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: bypass, zero register,
// RAW stall, scoreboard saturation and underflow.
module tb_wb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        iss_valid;
  logic        iss_we;
  logic [4:0]  iss_dst;
  logic        rs_busy;
  logic        rt_busy;
  logic        stall;
  logic        sb_err;

  int n_chk;
  int n_fail;

  wb_reg_file #(
    .MAX_PEND (3),
    .RESET_VAL(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_we    (wb_we),
    .wb_dst   (wb_dst),
    .wb_data  (wb_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .iss_valid(iss_valid),
    .iss_we   (iss_we),
    .iss_dst  (iss_dst),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .stall    (stall),
    .sb_err   (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we     = 1'b0;
    wb_dst    = 5'd0;
    wb_data   = 32'd0;
    iss_valid = 1'b0;
    iss_we    = 1'b0;
    iss_dst   = 5'd0;
  endtask

  task automatic issue(input logic [4:0] d);
    idle();
    iss_valid = 1'b1;
    iss_we    = 1'b1;
    iss_dst   = d;
  endtask

  task automatic wb(input logic [4:0] d,
                    input logic [31:0] v);
    idle();
    wb_we   = 1'b1;
    wb_dst  = d;
    wb_data = v;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    rs_addr = 5'd0;
    rt_addr = 5'd0;

    // reset with a write pending on the bus
    rst_n = 1'b0;
    wb(5'd5, 32'hDEAD_BEEF);
    rs_addr = 5'd5;
    #1;
    chk("rst_rs_data", rs_data, 32'd0);
    chk("rst_stall", stall, 1'b0);
    tick();
    tick();
    chk("rst_hold_rs", rs_data, 32'd0);
    rst_n = 1'b1;
    idle();
    #1;
    chk("post_rst_rs", rs_data, 32'd0);
    chk("post_rst_busy", rs_busy, 1'b0);
    chk("post_rst_err", sb_err, 1'b0);
    tick();
    chk("post_rst_rs2", rs_data, 32'd0);

    // issue r7, then retire it with bypass
    issue(5'd7);
    tick();
    idle();
    rs_addr = 5'd7;
    #1;
    chk("r7_busy", rs_busy, 1'b1);
    wb(5'd7, 32'h1234_5678);
    #1;
    chk("r7_bypass", rs_data, 32'h1234_5678);
    chk("r7_busy_ret", rs_busy, 1'b0);
    tick();
    idle();
    #1;
    chk("r7_stored", rs_data, 32'h1234_5678);
    chk("r7_busy_after", rs_busy, 1'b0);
    chk("r7_err", sb_err, 1'b0);

    // register zero
    wb(5'd0, 32'hFFFF_FFFF);
    iss_valid = 1'b1;
    iss_we    = 1'b1;
    iss_dst   = 5'd0;
    rs_addr   = 5'd0;
    rt_addr   = 5'd0;
    #1;
    chk("r0_bypass", rs_data, 32'd0);
    chk("r0_busy", rs_busy, 1'b0);
    tick();
    idle();
    #1;
    chk("r0_rs", rs_data, 32'd0);
    chk("r0_rt", rt_data, 32'd0);
    chk("r0_busy2", rs_busy, 1'b0);
    chk("r0_err", sb_err, 1'b0);

    // RAW stall on r3
    issue(5'd3);
    tick();
    idle();
    rt_addr = 5'd3;
    #1;
    chk("r3_busy", rt_busy, 1'b1);
    chk("r3_stall", stall, 1'b1);
    tick();
    wb(5'd3, 32'hA5A5_0003);
    #1;
    chk("r3_busy_ret", rt_busy, 1'b0);
    chk("r3_stall_ret", stall, 1'b0);
    chk("r3_bypass", rt_data, 32'hA5A5_0003);
    tick();
    idle();
    #1;
    chk("r3_busy_after", rt_busy, 1'b0);
    chk("r3_stored", rt_data, 32'hA5A5_0003);
    chk("r3_err", sb_err, 1'b0);

    // simultaneous issue and retire on r9
    issue(5'd9);
    tick();
    wb(5'd9, 32'h0000_0099);
    iss_valid = 1'b1;
    iss_we    = 1'b1;
    iss_dst   = 5'd9;
    rs_addr   = 5'd9;
    #1;
    chk("r9_busy_same", rs_busy, 1'b0);
    tick();
    idle();
    #1;
    chk("r9_busy_next", rs_busy, 1'b1);
    chk("r9_data", rs_data, 32'h0000_0099);
    chk("r9_err", sb_err, 1'b0);
    wb(5'd9, 32'h0000_0999);
    tick();
    idle();
    #1;
    chk("r9_clear", rs_busy, 1'b0);

    // two pending on r2: first retire still busy
    issue(5'd2);
    tick();
    issue(5'd2);
    tick();
    wb(5'd2, 32'h0000_0002);
    rs_addr = 5'd2;
    #1;
    chk("r2_busy_p2", rs_busy, 1'b1);
    tick();
    wb(5'd2, 32'h0000_0022);
    #1;
    chk("r2_busy_p1", rs_busy, 1'b0);
    tick();
    idle();
    #1;
    chk("r2_data", rs_data, 32'h0000_0022);
    chk("r2_err", sb_err, 1'b0);

    // saturate r4
    rs_addr = 5'd4;
    for (int i = 0; i < 3; i++) begin
      issue(5'd4);
      tick();
    end
    idle();
    #1;
    chk("r4_busy_p3", rs_busy, 1'b1);
    chk("r4_err_p3", sb_err, 1'b0);
    issue(5'd4);
    tick();
    idle();
    #1;
    chk("r4_err_ovf", sb_err, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wb(5'd4, 32'h0000_0040 + i);
      tick();
    end
    idle();
    #1;
    chk("r4_busy_left1", rs_busy, 1'b1);
    wb(5'd4, 32'h0000_0044);
    #1;
    chk("r4_busy_last", rs_busy, 1'b0);
    tick();
    idle();
    #1;
    chk("r4_drained", rs_busy, 1'b0);
    chk("r4_err_sticky", sb_err, 1'b1);

    // reset, then underflow on r6
    rst_n = 1'b0;
    #1;
    chk("rst2_err", sb_err, 1'b0);
    rt_addr = 5'd7;
    #1;
    chk("rst2_r7", rt_data, 32'd0);
    tick();
    rst_n = 1'b1;
    wb(5'd6, 32'h6666_0006);
    rs_addr = 5'd6;
    tick();
    idle();
    #1;
    chk("r6_data", rs_data, 32'h6666_0006);
    chk("r6_busy", rs_busy, 1'b0);
    chk("r6_err", sb_err, 1'b1);
    tick();
    chk("r6_err_sticky", sb_err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Consumer end of the writeback interface: a 32x32 register file whose single write port takes the writeback stage's reg_write / data_to_reg / regdst outputs.
- Provides two combinational read ports (rs, rt) to decode, with same-cycle write-through bypass.
- Holds a per-register pending-write scoreboard. Decode marks a destination pending at issue; writeback clears it. Decode uses the busy flags to raise a RAW stall.

Parameters:
- MAX_PEND, 3, maximum in-flight writes tracked per register (counter saturates here).
- RESET_VAL, 32'h0000_0000, value loaded into registers 1..31 on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wb_we  input  1  write enable from writeback (reg_write)
- wb_dst  input  5  write address from writeback (regdst_out)
- wb_data  input  32  write data from writeback (data_to_reg)
- rs_addr  input  5  read port A address
- rt_addr  input  5  read port B address
- rs_data  output  32  read port A data
- rt_data  output  32  read port B data
- iss_valid  input  1  decode issues an instruction this cycle
- iss_we  input  1  issued instruction writes a register
- iss_dst  input  5  destination of issued instruction
- rs_busy  output  1  rs_addr has a pending write not yet retired
- rt_busy  output  1  rt_addr has a pending write not yet retired
- stall  output  1  rs_busy | rt_busy
- sb_err  output  1  sticky scoreboard error (overflow or underflow)

Behaviour:
- Reset (async, rst_n=0):
  - regs[1..31] <= RESET_VAL; all pend counters <= 0; sb_err <= 0.
  - Takes effect immediately and holds until rst_n rises; in-flight writes are discarded.
  - Outputs during reset: rs_data/rt_data = 0 for address 0, RESET_VAL otherwise; busy/stall = 0.
- Register 0:
  - Reads always return 0.
  - Writes to 0 are ignored.
  - Its pend counter is never incremented; rs_busy/rt_busy are 0 when the address is 0.
- Write:
  - On posedge clk, if wb_we && wb_dst!=0: regs[wb_dst] <= wb_data.
- Read (combinational, 0 latency):
  - rs_data = (wb_we && wb_dst==rs_addr && rs_addr!=0) ? wb_data : regs[rs_addr]. Same rule for rt.
- Scoreboard, one 2-bit counter pend[r] per register, updated at posedge:
  - inc = iss_valid && iss_we && iss_dst==r && r!=0.
  - dec = wb_we && wb_dst==r && r!=0.
  - inc && !dec: if pend[r]==MAX_PEND, hold the value and set sb_err; else pend+1.
  - dec && !inc: if pend[r]==0, hold at 0 and set sb_err (the write still occurs); else pend-1.
  - inc && dec on the same r: pend unchanged, no error.
  - Neither: hold.
- Busy flags (combinational):
  - rs_busy = rs_addr!=0 && pend[rs_addr]!=0 && !(pend[rs_addr]==1 && wb_we && wb_dst==rs_addr).
  - The last pending write retiring this cycle is satisfied by the bypass, so no stall. Same rule for rt.
  - Busy does not depend on the current-cycle issue: an instruction never stalls on its own destination.
- sb_err: sticky; cleared only by reset.
- No X on outputs after reset under any input sequence.

Test Plan:
- Reset then read: rst_n low with wb_we=1 wb_dst=5 wb_data=32'hDEAD_BEEF, release, read rs_addr=5 -> rs_data=0, busy=0, sb_err=0.
- Write/read with bypass: wb_we=1 wb_dst=7 wb_data=32'h1234_5678 with rs_addr=7 -> rs_data=32'h1234_5678 in the same cycle; next cycle with wb_we=0 -> still 32'h1234_5678.
- Zero register: write wb_dst=0 wb_data=32'hFFFF_FFFF, issue iss_dst=0 -> rs_data(0)=0, rs_busy=0, pend unchanged.
- RAW stall: issue iss_dst=3.
  - Next cycle rt_addr=3 -> rt_busy=1, stall=1.
  - Cycle with wb_we=1 wb_dst=3 wb_data=32'hA5A5_0003 -> rt_busy=0, rt_data=32'hA5A5_0003.
  - Next cycle -> rt_busy=0.
- Simultaneous issue and retire on reg 9 with pend=1 -> pend stays 1, rs_busy(9)=1 the next cycle, sb_err=0.
- Errors:
  - Four issues to reg 4 with no writeback -> pend=3, sb_err=1 after the 4th.
  - After reset: wb_we to reg 6 with pend=0 -> reg written, pend=0, sb_err=1.
